mux_scan_sequencer: RTL and testbench

Select sequencer and result collector for the 4:1 mux datapath. It steps the mux select through channels 0..3 and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux output and assembles the four samples into a 4-bit frame. The frame goes downstream over a valid/ready handshake. The block drives the mux `s` input and consumes its `y` output.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/dwell_counter.sv | 37 +++
 rtl/mux_scan_sequencer.sv | 118 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer and its dwell counter.
package mux_scan_pkg;

   localparam int NCH     = 4;
   localparam int SEL_W   = 2;
   localparam int DWELL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/dwell_counter.sv
// Up-counter that runs 0..LAST while enabled, pulses tc on its final count
// and wraps to zero on that same edge. clr forces the count back to zero.
module dwell_counter #(
   parameter int          W    = 4,
   parameter logic [W-1:0] LAST = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt_q, cnt_d;

   // Terminal count is only meaningful while the counter is actually running.
   always_comb begin
      tc = en && (cnt_q == LAST);
   end

   // Next count: clear wins, otherwise advance and wrap on terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through channels 0..3, holding each for DWELL cycles,
// samples the mux output at the end of each dwell and hands the assembled
// 4-bit frame downstream.
// Handshake: a frame transfers on a rising edge where frame_valid and
// frame_ready are both high; frame and frame_valid stay stable until then.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [NCH-1:0]   frame,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic             busy
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [NCH-2:0]   shadow_q, shadow_d;
   logic [NCH-1:0]   frame_q, frame_d;
   logic             frame_valid_q, frame_valid_d;
   logic             cnt_clr, cnt_en, cnt_tc;

   dwell_counter #(
      .W    (DWELL_W),
      .LAST (DWELL_LAST)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // Next-state, channel stepping, sample capture and frame hand-off.
   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      shadow_d      = shadow_q;
      frame_d       = frame_q;
      frame_valid_d = frame_valid_q;
      cnt_clr       = 1'b0;
      cnt_en        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               ch_d    = '0;
               cnt_clr = 1'b1;
            end
         end
         SCAN: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               if (ch_q != SEL_W'(NCH - 1)) begin
                  shadow_d[ch_q] = y_in;
                  ch_d           = ch_q + SEL_W'(1);
               end else begin
                  // Last channel goes straight into the frame, skipping the shadow.
                  frame_d       = {y_in, shadow_q};
                  frame_valid_d = 1'b1;
                  state_d       = HOLD;
               end
            end
         end
         HOLD: begin
            if (frame_valid_q && frame_ready) begin
               frame_valid_d = 1'b0;
               ch_d          = '0;
               if (cont) begin
                  state_d = SCAN;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            ch_d    = '0;
         end
      endcase
   end

   // State, channel, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         shadow_q      <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         shadow_q      <= shadow_d;
         frame_q       <= frame_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   // Outputs come straight from registers; the channel is parked at 0 in IDLE.
   always_comb begin
      sel         = ch_q;
      frame       = frame_q;
      frame_valid = frame_valid_q;
      busy        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a DWELL=2 instance for single scans,
// backpressure and reset cases, and a DWELL=1 instance for continuous mode.
module tb_mux_scan_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DWELL=2 instance signals
   logic       rst2_n, start2, cont2, rdy2, y2;
   logic [1:0] sel2;
   logic [3:0] frame2, pat2;
   logic       fv2, busy2;

   // DWELL=1 instance signals
   logic       rst1_n, start1, cont1, rdy1, y1;
   logic [1:0] sel1;
   logic [3:0] frame1, pat1;
   logic       fv1, busy1;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   // Independent 4:1 mux model standing in for mux4x1.
   function automatic logic mux4x1_model(input logic [3:0] d, input logic [1:0] s);
      case (s)
         2'd0:    return d[0];
         2'd1:    return d[1];
         2'd2:    return d[2];
         default: return d[3];
      endcase
   endfunction

   assign y2 = mux4x1_model(pat2, sel2);
   assign y1 = mux4x1_model(pat1, sel1);

   mux_scan_sequencer #(.DWELL(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .start(start2), .cont(cont2), .y_in(y2),
      .sel(sel2), .frame(frame2), .frame_valid(fv2), .frame_ready(rdy2),
      .busy(busy2)
   );

   mux_scan_sequencer #(.DWELL(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .start(start1), .cont(cont1), .y_in(y1),
      .sel(sel1), .frame(frame1), .frame_valid(fv1), .frame_ready(rdy1),
      .busy(busy1)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One scan on the DWELL=2 instance, checked cycle by cycle.
   // noise=1 pulses start and frame_ready while scanning; output must not change.
   task automatic run_scan2(input logic [3:0] pat, input logic [3:0] exp_f, input bit noise);
      pat2   = pat;
      rdy2   = !noise;
      start2 = 1'b1;
      tick();                       // E0
      start2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("scan_sel", sel2, k / 2);
         chk("scan_no_early_valid", fv2, 0);
         chk("scan_busy", busy2, 1);
         if (noise) begin
            case (k)
               3: start2 = 1'b1;
               4: start2 = 1'b0;
               5: rdy2   = 1'b1;
               6: rdy2   = 1'b0;
               default: ;
            endcase
         end
         tick();
      end
      chk("scan_valid", fv2, 1);
      chk("scan_frame", frame2, exp_f);
      for (int i = 0; i < 4; i++) begin
         chk("scan_frame_vs_mux", frame2[i], mux4x1_model(pat, 2'(i)));
      end
      rdy2 = 1'b1;
      tick();                       // transfer edge
      chk("scan_valid_one_cycle", fv2, 0);
      chk("scan_idle_busy", busy2, 0);
      chk("scan_idle_sel", sel2, 0);
      chk("scan_frame_kept", frame2, exp_f);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] pat;
      logic [3:0] exp_frame;
      bit         noise;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{pat: 4'b1010, exp_frame: 4'b1010, noise: 1'b0};
      vecs[1] = '{pat: 4'b0111, exp_frame: 4'b0111, noise: 1'b0};
      vecs[2] = '{pat: 4'b0000, exp_frame: 4'b0000, noise: 1'b0};
      vecs[3] = '{pat: 4'b1111, exp_frame: 4'b1111, noise: 1'b0};
      vecs[4] = '{pat: 4'b1010, exp_frame: 4'b1010, noise: 1'b1};
      vecs[5] = '{pat: 4'b0101, exp_frame: 4'b0101, noise: 1'b0};

      rst2_n = 1'b0; start2 = 1'b0; cont2 = 1'b0; rdy2 = 1'b0; pat2 = 4'b0000;
      rst1_n = 1'b0; start1 = 1'b0; cont1 = 1'b0; rdy1 = 1'b0; pat1 = 4'b0000;

      // Reset values
      tick();
      tick();
      chk("rst_sel2", sel2, 0);
      chk("rst_frame2", frame2, 0);
      chk("rst_valid2", fv2, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_sel1", sel1, 0);
      chk("rst_frame1", frame1, 0);
      chk("rst_valid1", fv1, 0);
      chk("rst_busy1", busy1, 0);
      rst2_n = 1'b1;
      rst1_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_busy", busy2, 0);
         chk("idle_sel", sel2, 0);
         chk("idle_valid", fv2, 0);
      end

      // Table-driven single scans (includes ignored-input and integration cases)
      for (int v = 0; v < 6; v++) begin
         run_scan2(vecs[v].pat, vecs[v].exp_frame, vecs[v].noise);
         tick();
      end

      // Backpressure: ready low for 5 cycles after valid
      pat2   = 4'b0110;
      rdy2   = 1'b0;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      for (int j = 0; j < 5; j++) begin
         chk("bp_valid_held", fv2, 1);
         chk("bp_frame_held", frame2, 4'b0110);
         chk("bp_busy", busy2, 1);
         tick();
      end
      chk("bp_valid_before_xfer", fv2, 1);
      rdy2 = 1'b1;
      tick();
      chk("bp_valid_cleared", fv2, 0);
      chk("bp_busy_fall", busy2, 0);
      chk("bp_frame_kept", frame2, 4'b0110);

      // Reset mid-scan while sel=2
      rdy2   = 1'b1;
      pat2   = 4'b1001;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("mid_sel_before_rst", sel2, 2);
      rst2_n = 1'b0;
      #1;
      chk("mid_rst_sel", sel2, 0);
      chk("mid_rst_busy", busy2, 0);
      chk("mid_rst_valid", fv2, 0);
      chk("mid_rst_frame", frame2, 0);
      tick();
      rst2_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk("mid_no_valid", fv2, 0);
         chk("mid_no_busy", busy2, 0);
         tick();
      end
      run_scan2(4'b1100, 4'b1100, 1'b0);

      // Continuous mode, DWELL=1: period 5, back-to-back frames
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b1000);
      cont1  = 1'b1;
      rdy1   = 1'b1;
      pat1   = 4'b0001;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int c = 0; c < 4; c++) begin
            chk("cont_sel", sel1, c);
            chk("cont_no_valid", fv1, 0);
            chk("cont_busy", busy1, 1);
            tick();
         end
         chk("cont_valid", fv1, 1);
         if (exp_q.size() > 0) chk("cont_frame", frame1, exp_q.pop_front());
         else                  chk("cont_exp_q_underflow", 1, 0);
         if (f == 0) begin
            pat1 = 4'b1000;
         end else begin
            cont1 = 1'b0;
         end
         tick();
         chk("cont_valid_cleared", fv1, 0);
         chk("cont_sel_after_xfer", sel1, 0);
      end
      chk("cont_stop_busy", busy1, 0);
      chk("cont_exp_q_empty", exp_q.size(), 0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
